// File: rtl/mod_counter_sync.sv
// mod_counter_sync: parametrised up/down modulo counter with load, cascade tc, sticky wrap flag; Gray output enabled by MOD_COUNTER_GRAY_EN
module mod_counter_sync #(
  parameter int unsigned WIDTH = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             msb,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] q_gray
);
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);
  logic [WIDTH:0] qx, dx;
  logic [WIDTH-1:0] q_next;
  logic wrap;
  // next count at WIDTH+1 bits so MODULUS = 2^WIDTH never aliases
  always_comb begin
    qx = {1'b0, q};
    dx = {1'b0, d};
    tc = en & (up ? qx == MAXV : qx == '0);
    wrap = tc & ~load;
    q_next = WIDTH'(load ? (dx > MAXV ? MAXV : dx) :
                    en ? (tc ? (up ? '0 : MAXV) : (up ? qx + 1'b1 : qx - 1'b1)) : qx);
  end
  assign msb = q[WIDTH-1];
  // count register and sticky wrap flag; a wrap beats clr_ovf
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      ovf <= 1'b0;
    end else begin
      q <= q_next;
      ovf <= wrap | (ovf & ~clr_ovf);
    end
`ifdef MOD_COUNTER_GRAY_EN
  // Gray image of the next count, so it never lags q
  always_ff @(posedge clk or posedge rst)
    if (rst) q_gray <= '0;
    else q_gray <= q_next ^ (q_next >> 1);
`else
  assign q_gray = '0;
`endif
endmodule
